u_phase_seq_l17: RTL and testbench

- Phase sequencer and inner tap counters for layer 17 of the SqueezeNext accelerator.
- Drives the 3-bit phase code u and the j_zero, k_zero and temp_zero qualifiers consumed by the layer-17 z counter.
- Consumes that counter's z_zero terminal pulse, together with L_zero from the L counter, to step through phases and tiles.
- Raises layer_done when the whole layer has been processed.

---
 rtl/l17_pkg.sv | 12 +
 rtl/u_phase_seq_l17_tap.sv | 20 ++
 rtl/u_phase_seq_l17.sv | 86 ++++++++
 tb/tb_u_phase_seq_l17.sv | 111 +++++++++++
 4 files changed

// File: rtl/l17_pkg.sv
// l17_pkg: shared phase encodings and counter widths for the layer-17 sequencer and z counter
package l17_pkg;
  localparam int TAP_W = 3;
  localparam int TILE_W = 4;
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SQ1   = 3'd1,
    PH_SQ2   = 3'd2,
    PH_SEP31 = 3'd3,
    PH_SEP13 = 3'd4
  } phase_e;
endpackage

// File: rtl/u_phase_seq_l17_tap.sv
// tap_counter_l17: wrap counter that pulses wrap_o combinationally on the enabled cycle at last_i
// ports: clk, rst (async, active-low), en_i count enable, clr_i synchronous clear,
//        last_i final count value, wrap_o wrap pulse (en_i && count == last_i)
module tap_counter_l17 #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] last_i,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && cnt_q == last_i;
  assign cnt_d = (clr_i || wrap_o) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/u_phase_seq_l17.sv
// u_phase_seq_l17: layer-17 phase/tile sequencer with k (3x1) and j (1x3) tap counters
// ports: clk, rst (async, active-low), start begin request (idle only), abort sync flush,
//        L_zero / z_zero terminal pulses in, u phase code, k_zero / j_zero combinational tap wraps,
//        temp_zero registered z-counter clear pulse, tile pass index, layer_done end-of-layer pulse
module u_phase_seq_l17
  import l17_pkg::*;
#(
  parameter int TILES  = 4,
  parameter int K_LAST = 2,
  parameter int J_LAST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              L_zero,
  input  logic              z_zero,
  output logic [2:0]        u,
  output logic              k_zero,
  output logic              j_zero,
  output logic              temp_zero,
  output logic [TILE_W-1:0] tile,
  output logic              layer_done
);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES - 1);
  phase_e u_q, u_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic tz_q, tz_d, done_q, done_d;
  logic pass, tap_clr;
  // a z_zero in our own temp_zero cycle is the echo of that clear, not a finished pass
  assign pass = z_zero && !tz_q && u_q != PH_IDLE;
  always_comb begin
    u_d = u_q;
    tile_d = tile_q;
    tz_d = 1'b0;
    done_d = 1'b0;
    if (abort) begin
      u_d = PH_IDLE;
      tile_d = '0;
      tz_d = u_q != PH_IDLE;
    end else if (u_q == PH_IDLE) begin
      if (start) begin
        u_d = PH_SQ1;
        tile_d = '0;
        tz_d = 1'b1;
      end
    end else if (pass) begin
      if (tile_q != TILE_LAST) tile_d = tile_q + TILE_W'(1);
      else if (u_q == PH_SEP13) begin
        u_d = PH_IDLE;
        tile_d = '0;
        done_d = 1'b1;
      end else begin
        u_d = phase_e'(u_q + 3'd1);
        tile_d = '0;
        tz_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      u_q <= PH_IDLE;
      tile_q <= '0;
      tz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      u_q <= u_d;
      tile_q <= tile_d;
      tz_q <= tz_d;
      done_q <= done_d;
    end
  // taps restart on every phase change and on every z-counter clear
  assign tap_clr = u_d != u_q || tz_q;
  tap_counter_l17 #(.W(TAP_W)) u_k (
    .clk(clk), .rst(rst), .en_i(u_q == PH_SEP31 && L_zero), .clr_i(tap_clr),
    .last_i(TAP_W'(K_LAST)), .wrap_o(k_zero)
  );
  tap_counter_l17 #(.W(TAP_W)) u_j (
    .clk(clk), .rst(rst), .en_i(u_q == PH_SEP13 && L_zero), .clr_i(tap_clr),
    .last_i(TAP_W'(J_LAST)), .wrap_o(j_zero)
  );
  assign u = u_q;
  assign tile = tile_q;
  assign temp_zero = tz_q;
  assign layer_done = done_q;
endmodule

// File: tb/tb_u_phase_seq_l17.sv
// tb_u_phase_seq_l17: scoreboard bench; driver queues per-cycle expectations, negedge monitor checks them
module tb_u_phase_seq_l17;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, L_zero = 1'b0, z_zero = 1'b0;
  logic [2:0] u;
  logic [3:0] tile;
  logic k_zero, j_zero, temp_zero, layer_done;
  typedef struct packed {
    logic [2:0] u;
    logic [3:0] tile;
    logic tz, done, kz, jz;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  u_phase_seq_l17 #(.TILES(4), .K_LAST(2), .J_LAST(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .L_zero(L_zero), .z_zero(z_zero),
    .u(u), .k_zero(k_zero), .j_zero(j_zero), .temp_zero(temp_zero), .tile(tile),
    .layer_done(layer_done)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("u", 8'(u), 8'(e.u));
      chk("tile", 8'(tile), 8'(e.tile));
      chk("temp_zero", 8'(temp_zero), 8'(e.tz));
      chk("layer_done", 8'(layer_done), 8'(e.done));
      chk("k_zero", 8'(k_zero), 8'(e.kz));
      chk("j_zero", 8'(j_zero), 8'(e.jz));
    end
  task automatic cyc(input logic s, a, lz, zz, input logic [2:0] eu, input logic [3:0] et,
                     input logic etz, ed, ekz, ejz);
    start = s;
    abort = a;
    L_zero = lz;
    z_zero = zz;
    sb.push_back('{eu, et, etz, ed, ekz, ejz});
    @(posedge clk);
    #1;
  endtask
  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
  endtask
  task automatic pulses(input int p, input int n);
    for (int t = 0; t < n; t++) cyc(0, 0, 0, 1, 3'(p), 4'(t), 0, 0, 0, 0);
  endtask
  task automatic tz_cyc(input int p);
    cyc(0, 0, 0, 0, 3'(p), 4'd0, 1, 0, 0, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u", 8'(u), 8'd0);
    chk("rst_tile", 8'(tile), 8'd0);
    chk("rst_tz", 8'(temp_zero), 8'd0);
    chk("rst_done", 8'(layer_done), 8'd0);
    rst = 1'b1;
    repeat (20) idle_cyc();
    // start, then a z_zero echo in the temp_zero cycle must not advance tile
    cyc(1, 0, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3'd1, 4'd0, 1, 0, 0, 0);
    for (int p = 1; p <= 4; p++) begin
      if (p > 1) tz_cyc(p);
      if (p == 3) for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 3'd3, 4'd0, 0, 0, i % 3 == 2, 0);
      if (p == 4) for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 3'd4, 4'd0, 0, 0, 0, i % 3 == 2);
      for (int t = 0; t < 4; t++) cyc(0, 0, p < 3, 1, 3'(p), 4'(t), 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 3'd0, 4'd0, 0, 1, 0, 0);
    idle_cyc();
    // abort beats start in idle and raises no temp_zero there
    cyc(1, 1, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
    idle_cyc();
    // walk to u=3 tile=2 k=1, then abort with z_zero, L_zero and start all high
    cyc(1, 0, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
    tz_cyc(1);
    pulses(1, 4);
    tz_cyc(2);
    pulses(2, 4);
    tz_cyc(3);
    pulses(3, 2);
    cyc(0, 0, 1, 0, 3'd3, 4'd2, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 3'd3, 4'd2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 3'd0, 4'd0, 1, 0, 0, 0);
    idle_cyc();
    // async reset mid-phase 2
    cyc(1, 0, 0, 0, 3'd0, 4'd0, 0, 0, 0, 0);
    tz_cyc(1);
    pulses(1, 4);
    tz_cyc(2);
    cyc(0, 0, 0, 1, 3'd2, 4'd0, 0, 0, 0, 0);
    chk("pre_arst_u", 8'(u), 8'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_u", 8'(u), 8'd0);
    chk("arst_tile", 8'(tile), 8'd0);
    chk("arst_tz", 8'(temp_zero), 8'd0);
    chk("arst_done", 8'(layer_done), 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) idle_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
